// File: rtl/pipe_mem_pkg.sv
// pipe_mem_pkg: shared types and defaults for the pipeline memory-port arbiter.
//   arb_state_t : grant FSM states (IDLE / ACCESS / RESP)
//   gnt_t       : which requester owns the current memory transaction
//   AW_DEF/DW_DEF, STARVE_W, TIMER_W : default widths
package pipe_mem_pkg;

    localparam int AW_DEF   = 32;
    localparam int DW_DEF   = 32;
    localparam int STARVE_W = 4;
    localparam int TIMER_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: loadable down-counter used as the ACCESS timeout.
//   clk, reset (sync, active-low)
//   load    : (re)arm with 'period'; a period of 0 disarms the timer
//   period  : number of counted cycles until expiry
//   dec     : count one cycle
//   expired : armed and count has reached zero
module mem_arb_timer
    import pipe_mem_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] period,
    input  logic         dec,
    output logic         expired
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         armed_q, armed_d;

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (load) begin
            // Loading period-1 means expiry is flagged during the period'th counted cycle.
            armed_d = (period != '0);
            cnt_d   = (period != '0) ? (period - W'(1)) : '0;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign expired = armed_q && (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch (I)
// and data memory (D) ports.
//   if_*  : fetch requester (level req held until if_ready pulse)
//   dm_*  : data requester  (level req held until dm_ready pulse)
//   mem_* : memory side; mem_req held until mem_ack, mem_err pulses on timeout
//   stall_f / stall_m : requester waiting, fed to the hazard unit
//   dbg_state : current grant FSM state
// Handshake: a requester raises req with stable address/data and holds it until
// its ready pulse (one cycle, with rdata valid). On the memory side mem_req is held
// with stable address/data until the cycle mem_ack is seen high in ACCESS; mem_ack
// at any other time is ignored.
module mem_port_arbiter
    import pipe_mem_pkg::*;
#(
    parameter int AW             = AW_DEF,
    parameter int DW             = DW_DEF,
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT        = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          stall_f,
    output logic          stall_m,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          mem_err,
    output arb_state_t    dbg_state
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_DATA_BURST);

    arb_state_t            state_q, state_d;
    gnt_t                  gnt_q, gnt_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [AW-1:0]         mem_addr_q, mem_addr_d;
    logic [DW-1:0]         mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]         if_rdata_q, if_rdata_d;
    logic [DW-1:0]         dm_rdata_q, dm_rdata_d;
    logic                  if_ready_q, if_ready_d;
    logic                  dm_ready_q, dm_ready_d;
    logic                  mem_err_q, mem_err_d;
    logic                  timer_load;
    logic                  timer_expired;
    logic                  pick_i;

    mem_arb_timer #(.W(TIMER_W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .period  (TIMER_W'(TIMEOUT)),
        .dec     (state_q == ACCESS),
        .expired (timer_expired)
    );

    // Fetch wins only when it is alone or data has used up its burst allowance.
    assign pick_i = if_req && (!dm_req || (starve_q == STARVE_MAX));

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        mem_err_d   = 1'b0;
        timer_load  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    if (pick_i) begin
                        gnt_d       = GNT_I;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        starve_d    = '0;
                    end else begin
                        gnt_d       = GNT_D;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        if (!if_req) begin
                            starve_d = '0;
                        end else if (starve_q != STARVE_MAX) begin
                            starve_d = starve_q + STARVE_W'(1);
                        end
                    end
                    mem_req_d  = 1'b1;
                    timer_load = 1'b1;
                    state_d    = ACCESS;
                end
            end

            ACCESS: begin
                // Ready/err are registered here so they appear during the RESP cycle.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (gnt_q == GNT_I) begin
                        if_rdata_d = mem_rdata;
                        if_ready_d = 1'b1;
                    end else begin
                        if (!mem_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                        dm_ready_d = 1'b1;
                    end
                end else if (timer_expired) begin
                    mem_req_d = 1'b0;
                    mem_err_d = 1'b1;
                    state_d   = RESP;
                    if (gnt_q == GNT_I) begin
                        if_rdata_d = '0;
                        if_ready_d = 1'b1;
                    end else begin
                        dm_rdata_d = '0;
                        dm_ready_d = 1'b1;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_I;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign mem_err   = mem_err_q;
    assign stall_f   = if_req & ~if_ready_q;
    assign stall_m   = dm_req & ~dm_ready_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MAX_DATA_BURST=4, TIMEOUT=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_port_arbiter;
    import pipe_mem_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          stall_f;
    logic          stall_m;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          mem_err;
    arb_state_t    dbg_state;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_DATA_BURST(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .stall_f(stall_f), .stall_m(stall_m),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err),
        .dbg_state(dbg_state)
    );

    // Clock and global time limit
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One full clock, ending at the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, if_ready, dm_ready, mem_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 00000", {mem_req, mem_we, if_ready, dm_ready, mem_err});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h exp 0", mem_addr, mem_wdata, if_rdata, dm_rdata);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state got %0d exp %0d", dbg_state, IDLE);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fetch_read();
        // cycle 0
        if_req = 1'b1; if_addr = 32'h40;
        #1;
        checks++;
        if ({stall_f, mem_req} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_c0 stall_f,mem_req got %b exp 10", {stall_f, mem_req});
        end
        tick(); // cycle 1
        checks++;
        if ({mem_req, mem_we, stall_f} !== 3'b101 || mem_addr !== 32'h40) begin
            errors++;
            $display("FAIL fetch_c1 req,we,stall got %b addr %h exp 101 addr 40", {mem_req, mem_we, stall_f}, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h8C220004;
        tick(); // cycle 2
        mem_ack = 1'b0;
        checks++;
        if ({if_ready, dm_ready, stall_f, mem_req} !== 4'b1000 || if_rdata !== 32'h8C220004) begin
            errors++;
            $display("FAIL fetch_c2 rdy,drdy,stall,req got %b rdata %h exp 1000 rdata 8c220004",
                     {if_ready, dm_ready, stall_f, mem_req}, if_rdata);
        end
        if_req = 1'b0;
        tick(); // cycle 3
        checks++;
        if (if_ready !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL fetch_c3 if_ready %b state %0d exp 0 IDLE", if_ready, dbg_state);
        end
    endtask

    task automatic test_data_read();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_wdata = 32'h0;
        #1;
        checks++;
        if (stall_m !== 1'b1) begin
            errors++;
            $display("FAIL dread_stall got %b exp 1", stall_m);
        end
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h200) begin
            errors++;
            $display("FAIL dread_c1 req %b we %b addr %h exp 1 0 200", mem_req, mem_we, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({dm_ready, if_ready, stall_m} !== 3'b100 || dm_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL dread_c2 drdy,irdy,stall got %b rdata %h exp 100 12345678",
                     {dm_ready, if_ready, stall_m}, dm_rdata);
        end
        dm_req = 1'b0;
        tick();
    endtask

    task automatic test_data_write_wait();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
        mem_rdata = 32'hBAD0BAD0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if ({mem_req, mem_we, dm_ready} !== 3'b110 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL dwrite_hold c%0d req,we,rdy got %b addr %h wdata %h exp 110 100 deadbeef",
                         c, {mem_req, mem_we, dm_ready}, mem_addr, mem_wdata);
            end
            if (c == 3) mem_ack = 1'b1;
        end
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({dm_ready, if_ready, mem_req} !== 3'b100 || dm_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL dwrite_resp rdy,irdy,req got %b rdata %h exp 100 12345678",
                     {dm_ready, if_ready, mem_req}, dm_rdata);
        end
        dm_req = 1'b0; dm_we = 1'b0;
        tick();
        checks++;
        if (dm_ready !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL dwrite_end dm_ready %b state %0d exp 0 IDLE", dm_ready, dbg_state);
        end
    endtask

    task automatic test_back_to_back();
        logic [0:0] exp_q[$];
        logic [0:0] got;
        int         n_grants;
        int         last_cyc;
        exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        n_grants = 0;
        last_cyc = -1;
        if_req = 1'b1; if_addr = 32'h80;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        for (int cyc = 0; cyc < 60 && n_grants < 10; cyc++) begin
            tick();
            // zero-wait memory: ack whenever a request is outstanding
            mem_ack = mem_req;
            mem_rdata = 32'hA5A50000 | {16'h0, mem_addr[15:0]};
            if (if_ready && dm_ready) begin
                checks++;
                errors++;
                $display("FAIL b2b_both_ready at cycle %0d got 11 exp one-hot", cyc);
            end
            if (if_ready || dm_ready) begin
                got = dm_ready;
                checks++;
                if (got !== exp_q[n_grants]) begin
                    errors++;
                    $display("FAIL b2b_order grant %0d got %s exp %s", n_grants,
                             got ? "D" : "I", exp_q[n_grants] ? "D" : "I");
                end
                checks++;
                if ((if_ready && if_rdata !== 32'hA5A50080) || (dm_ready && dm_rdata !== 32'hA5A50300)) begin
                    errors++;
                    $display("FAIL b2b_rdata grant %0d got if %h dm %h exp a5a50080 / a5a50300",
                             n_grants, if_rdata, dm_rdata);
                end
                if (last_cyc >= 0) begin
                    checks++;
                    if (cyc - last_cyc != 3) begin
                        errors++;
                        $display("FAIL b2b_spacing grant %0d got %0d exp 3", n_grants, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                n_grants++;
            end
        end
        checks++;
        if (n_grants != 10) begin
            errors++;
            $display("FAIL b2b_count got %0d exp 10", n_grants);
        end
        if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400; mem_ack = 1'b0;
        tick();
        while (mem_req === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL timeout_len got %0d exp 8", n);
        end
        checks++;
        if ({mem_err, dm_ready, if_ready, mem_req} !== 4'b1100 || dm_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_resp err,drdy,irdy,req got %b rdata %h exp 1100 0",
                     {mem_err, dm_ready, if_ready, mem_req}, dm_rdata);
        end
        dm_req = 1'b0;
        tick();
        checks++;
        if ({mem_err, dm_ready} !== 2'b00 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL timeout_end err,rdy got %b state %0d exp 00 IDLE", {mem_err, dm_ready}, dbg_state);
        end
    endtask

    task automatic test_reset_mid_access();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
        tick();
        checks++;
        if (mem_req !== 1'b1 || dbg_state !== ACCESS) begin
            errors++;
            $display("FAIL rst_mid_pre req %b state %0d exp 1 ACCESS", mem_req, dbg_state);
        end
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
        tick();
        checks++;
        if ({mem_req, mem_we, if_ready, dm_ready, mem_err} !== 5'b0 ||
            {mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL rst_mid_clear ctrl %b data %h %h %h %h state %0d exp 0 IDLE",
                     {mem_req, mem_we, if_ready, dm_ready, mem_err},
                     mem_addr, mem_wdata, if_rdata, dm_rdata, dbg_state);
        end
        reset = 1'b1; dm_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({if_ready, dm_ready, mem_req} !== 3'b000 || dbg_state !== IDLE) begin
                errors++;
                $display("FAIL rst_mid_late_ack c%0d irdy,drdy,req got %b state %0d exp 000 IDLE",
                         c, {if_ready, dm_ready, mem_req}, dbg_state);
            end
        end
        mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_stray_ack();
        mem_ack = 1'b1; mem_rdata = 32'h11112222;
        tick();
        mem_ack = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if ({if_ready, dm_ready, mem_req, mem_err} !== 4'b0000 || dbg_state !== IDLE ||
                if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
                errors++;
                $display("FAIL stray_ack c%0d irdy,drdy,req,err got %b state %0d rdata %h %h exp 0000 IDLE 0 0",
                         c, {if_ready, dm_ready, mem_req, mem_err}, dbg_state, if_rdata, dm_rdata);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_data_read();
        test_data_write_wait();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        test_stray_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch port and data-memory port.
- Registered grant FSM drives the memory handshake and returns read data and ready pulses to each requester.
- Generates stall requests, which the hazard unit ORs into its fetch stall and memory-stage stall.
- Sits between DataPath and the external memory model, beside hazardUnit.

Parameters:
- AW, 32, address width (byte address, passed through unchanged)
- DW, 32, data width
- MAX_DATA_BURST, 4, consecutive data grants allowed while fetch is waiting before fetch is forced; range 1..15
- TIMEOUT, 64, cycles in ACCESS without mem_ack before abort; 0 disables timeout; range 0..255

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; level, held until if_ready
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched instruction; valid when if_ready=1
- if_ready  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request; level, held until dm_ready
- dm_we  in  1  1=write, 0=read
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- dm_rdata  out  DW  load data; valid when dm_ready=1
- dm_ready  out  1  one-cycle completion pulse for data
- stall_f  out  1  if_req & ~if_ready (combinational)
- stall_m  out  1  dm_req & ~dm_ready (combinational)
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid with mem_ack
- mem_ack  in  1  memory completion; may assert the same cycle mem_req rises
- mem_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (reset=0 at a clk edge):
  - State goes to IDLE.
  - mem_req, mem_we, if_ready, dm_ready and mem_err go to 0.
  - mem_addr, mem_wdata, if_rdata and dm_rdata go to 0.
  - Starvation and timeout counters go to 0.
  - Reset mid-ACCESS drops mem_req at that same edge. No ready pulse is produced for the aborted transaction.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Only dm_req: grant D.
  - Only if_req: grant I.
  - Both requests: grant D unless starve_cnt == MAX_DATA_BURST, in which case grant I.
  - On grant, register mem_addr/mem_we/mem_wdata from the granted port. Fetch forces we=0 and wdata=0.
  - Set mem_req=1, clear the timeout counter, go to ACCESS.
- starve_cnt (4 bits):
  - +1 on each D grant made while if_req=1.
  - Cleared on every I grant.
  - Cleared on a D grant made while if_req=0.
  - Saturates at MAX_DATA_BURST.
- ACCESS:
  - mem_req and the address/data are held stable.
  - On mem_ack: mem_req goes to 0 and the state goes to RESP.
    - Granted read: capture mem_rdata into if_rdata or dm_rdata.
    - Data write: dm_rdata holds its previous value.
  - Timeout (TIMEOUT≠0, timer reaches TIMEOUT-1 without ack): mem_req goes to 0 and the state goes to RESP. The granted rdata is set to 0 and mem_err pulses in RESP.
- RESP:
  - Exactly one cycle.
  - Pulse the granted port's ready, then return to IDLE.
  - Requests are not sampled in RESP. The requester still holds req this cycle, and the stall drops because ready=1.
- Latency:
  - Request seen in IDLE at cycle 0, mem_req=1 in cycle 1.
  - mem_ack in cycle 1+k gives ready in cycle 2+k.
  - Minimum 3 cycles per access. Back-to-back accesses issue every 3 cycles with zero-wait memory.
- mem_ack outside ACCESS is ignored. At most one ready is asserted per cycle. if_ready and dm_ready are never high together.
- Requests that drop before ready are a protocol violation. The grant still completes and the ready pulse is still issued.

Decomposition:
- Shared package pipe_mem_pkg:
  - State enum (IDLE/ACCESS/RESP).
  - Grant encoding (GNT_I, GNT_D).
  - Default widths AW/DW.
- One natural sub-module: mem_arb_timer, a loadable down-counter with expire flag and disable-when-zero. It is instantiated for the timeout.
- The starvation counter stays inline.

Test Plan:
- Fetch-only read:
  - Stimulus: if_addr=0x40, mem_ack the same cycle mem_req rises, mem_rdata=0x8C220004.
  - Required: mem_req in cycle 1, if_ready and if_rdata=0x8C220004 in cycle 2, stall_f=1 in cycles 0-1.
- Data write with 2 wait states:
  - Stimulus: dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF.
  - Required: mem_we=1 and address/data stable for 3 cycles, dm_ready 1 cycle after ack, dm_rdata unchanged.
- Simultaneous requests, MAX_DATA_BURST=4:
  - Stimulus: if_req and dm_req held continuously.
  - Required: grant order D,D,D,D,I,D…; starve_cnt returns to 0 after the I grant.
- Timeout:
  - Stimulus: TIMEOUT=8, mem_ack never asserted.
  - Required: mem_req drops after 8 ACCESS cycles; mem_err and dm_ready pulse together with dm_rdata=0; FSM back to IDLE.
- Reset mid-access:
  - Stimulus: reset=0 during ACCESS with pending ack.
  - Required: next edge gives mem_req=0 and all outputs 0; an ack arriving afterwards produces no ready.
- Stray ack:
  - Stimulus: mem_ack pulsed while in IDLE.
  - Required: no state change, no ready pulse.
